// File: rtl/sort_pkg.sv
// Shared types for the sorting-bin job scheduler: bin codes, FSM states and the move command.
package sort_pkg;

    typedef enum logic [1:0] {
        BIN_NONE    = 2'd0,
        BIN_METAL   = 2'd1,
        BIN_PLASTIC = 2'd2,
        BIN_GLASS   = 2'd3
    } bin_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_WINDOW,
        D_CLASSIFY,
        D_HOLD
    } detect_state_t;

    typedef enum logic [1:0] {
        I_IDLE,
        I_OFFER,
        I_WAIT
    } issue_state_t;

    typedef struct packed {
        logic [15:0] steps;
        logic        dir;
        bin_t        bin;
    } move_cmd_t;

    // Capacitive presence is implied; inductive-without-photo is an unknown item and is rejected.
    function automatic bin_t classify(input logic cap, input logic ind, input logic photo);
        bin_t b;
        b = BIN_NONE;
        if (cap) begin
            case ({ind, photo})
                2'b11:   b = BIN_METAL;
                2'b01:   b = BIN_PLASTIC;
                2'b00:   b = BIN_GLASS;
                default: b = BIN_NONE;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/sort_job_scheduler_if.sv
// Move-command handshake between the scheduler and the stepper executor.
interface sort_job_scheduler_if;
    import sort_pkg::*;

    logic        move_valid;
    logic        move_ready;
    logic [15:0] move_steps;
    logic        move_dir;
    bin_t        move_bin;
    logic        move_done;

    modport master (
        output move_valid, move_steps, move_dir, move_bin,
        input  move_ready, move_done
    );

    modport slave (
        input  move_valid, move_steps, move_dir, move_bin,
        output move_ready, move_done
    );

endinterface

// File: rtl/sort_job_fifo.sv
// Synchronous FIFO of bin codes; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sort_job_fifo
    import sort_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  bin_t                   din,
    output bin_t                   head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    bin_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sort_job_scheduler.sv
// Sensor classification and one-at-a-time move issue for the sorting-bin stepper.
// detect FSM:  D_IDLE     | waiting for capacitive detect
//              D_WINDOW   | accumulating sticky sensor flags
//              D_CLASSIFY | one cycle: classify and push (or flag overflow)
//              D_HOLD     | wait for capacitive release before re-arming
// issue FSM:   I_IDLE     | nothing offered
//              I_OFFER    | command offered, payload held until ready
//              I_WAIT     | command accepted, waiting for done
module sort_job_scheduler
    import sort_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int WINDOW_CYC    = 1000,
    parameter int FIFO_DEPTH    = 4,
    parameter int STEPS_METAL   = 300,
    parameter int STEPS_PLASTIC = 300,
    parameter int STEPS_GLASS   = 1000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        capacitive,
    input  logic                        inductive,
    input  logic                        photo,
    sort_job_scheduler_if.master        move,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int CW = $clog2(WINDOW_CYC + 1);

    logic [SYNC_STAGES-1:0] cap_sync, ind_sync, photo_sync;
    logic                   cap_s, ind_s, photo_s;

    detect_state_t  d_state, d_next;
    issue_state_t   i_state, i_next;
    logic [CW-1:0]  win_cnt;
    logic           win_tc;
    logic           flag_cap, flag_ind, flag_photo;
    bin_t           cls_bin;
    logic           push, pop, ovf_set, load_cmd;
    logic           fifo_full, fifo_empty;
    bin_t           fifo_head;
    move_cmd_t      cmd_q;

    function automatic move_cmd_t decode(input bin_t b);
        move_cmd_t c;
        c = '0;
        c.bin = b;
        case (b)
            BIN_METAL:   begin c.steps = 16'(STEPS_METAL);   c.dir = 1'b0; end
            BIN_PLASTIC: begin c.steps = 16'(STEPS_PLASTIC); c.dir = 1'b1; end
            BIN_GLASS:   begin c.steps = 16'(STEPS_GLASS);   c.dir = 1'b0; end
            default:     c = '0;
        endcase
        return c;
    endfunction

    // Capacitive is active-low, so its chain idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_sync   <= '1;
            ind_sync   <= '0;
            photo_sync <= '0;
        end else begin
            cap_sync   <= {cap_sync[SYNC_STAGES-2:0], capacitive};
            ind_sync   <= {ind_sync[SYNC_STAGES-2:0], inductive};
            photo_sync <= {photo_sync[SYNC_STAGES-2:0], photo};
        end
    end

    assign cap_s   = cap_sync[SYNC_STAGES-1];
    assign ind_s   = ind_sync[SYNC_STAGES-1];
    assign photo_s = photo_sync[SYNC_STAGES-1];
    assign win_tc  = (win_cnt == '0);
    assign cls_bin = classify(flag_cap, flag_ind, flag_photo);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_state    <= D_IDLE;
            i_state    <= I_IDLE;
            win_cnt    <= '0;
            flag_cap   <= 1'b0;
            flag_ind   <= 1'b0;
            flag_photo <= 1'b0;
            overflow   <= 1'b0;
            cmd_q      <= '0;
        end else begin
            d_state <= d_next;
            i_state <= i_next;
            if (d_state == D_IDLE && !cap_s) begin
                flag_cap   <= 1'b1;
                flag_ind   <= ind_s;
                flag_photo <= photo_s;
                win_cnt    <= CW'(WINDOW_CYC - 1);
            end else if (d_state == D_WINDOW) begin
                flag_cap   <= flag_cap | ~cap_s;
                flag_ind   <= flag_ind | ind_s;
                flag_photo <= flag_photo | photo_s;
                if (!win_tc) win_cnt <= win_cnt - 1'b1;
            end
            if (ovf_set)  overflow <= 1'b1;
            if (load_cmd) cmd_q    <= decode(fifo_head);
        end
    end

    always_comb begin
        i_next   = i_state;
        pop      = 1'b0;
        load_cmd = 1'b0;
        case (i_state)
            I_IDLE:  if (!fifo_empty) begin
                         i_next   = I_OFFER;
                         load_cmd = 1'b1;
                     end
            I_OFFER: if (move.move_ready) begin
                         pop    = 1'b1;
                         i_next = I_WAIT;
                     end
            I_WAIT:  if (move.move_done) i_next = I_IDLE;
            default: i_next = I_IDLE;
        endcase
    end

    always_comb begin
        d_next  = d_state;
        push    = 1'b0;
        ovf_set = 1'b0;
        case (d_state)
            D_IDLE:     if (!cap_s) d_next = D_WINDOW;
            D_WINDOW:   if (win_tc) d_next = D_CLASSIFY;
            D_CLASSIFY: begin
                d_next = D_HOLD;
                if (cls_bin != BIN_NONE) begin
                    if (fifo_full && !pop) ovf_set = 1'b1;
                    else                   push    = 1'b1;
                end
            end
            D_HOLD:     if (cap_s) d_next = D_IDLE;
            default:    d_next = D_IDLE;
        endcase
    end

    sort_job_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (cls_bin),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign move.move_valid = (i_state == I_OFFER);
    assign move.move_steps = cmd_q.steps;
    assign move.move_dir   = cmd_q.dir;
    assign move.move_bin   = cmd_q.bin;
    assign busy            = (i_state == I_WAIT);

endmodule
